// File: rtl/spec_readout_ctrl_pkg.sv
// spec_readout_ctrl_pkg: shared sizes, header magic, FSM states and pipeline tag
package spec_readout_ctrl_pkg;
  localparam int NofBits = 16;
  localparam int NofPoints = 1024;
  localparam int NofBins = 16;
  localparam int AddrW = 14;
  localparam int Words = NofPoints * NofBins;
  localparam logic [AddrW-1:0] LastAddr = AddrW'(Words - 1);
  localparam logic [15:0] HdrMagic = 16'hA55A;
  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, READ = 2'd2, DRAIN = 2'd3} state_t;
  typedef struct packed {
    logic vld;
    logic hdr;
    logic lst;
  } tag_t;
endpackage

// File: rtl/spec_readout_ctrl_bg_sub_sat.sv
// spec_readout_ctrl_bg_sub_sat: registered 32-bit subtract with floor at 0 and bypass
module spec_readout_ctrl_bg_sub_sat (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        clr,
  input  logic        en,
  input  logic        sub,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] q
);
  // result is forced to 0 whenever no valid word is in this stage
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) q <= '0;
    else q <= (clr || !en) ? '0 : sub ? ((a > b) ? a - b : '0) : a;
endmodule

// File: rtl/spec_readout_ctrl.sv
// spec_readout_ctrl: streams header plus every spectrum word out of DPRAM port B
module spec_readout_ctrl
  import spec_readout_ctrl_pkg::*;
#(
  parameter int RdLatency = 2
) (
  input  logic               clk_i,
  input  logic               rst_n_i,
  input  logic               start_i,
  input  logic               abort_i,
  input  logic               sub_bg_en_i,
  output logic [AddrW-1:0]   rd_addr_o,
  input  logic [31:0]        rd_data_i,
  output logic [9:0]         bg_addr_o,
  input  logic [31:0]        bg_data_i,
  output logic               port_sel_o,
  output logic               busy_o,
  output logic [NofBits-1:0] y0_o,
  output logic [NofBits-1:0] y0z_o,
  output logic               data_valid_o,
  output logic               frame_last_o,
  output logic               overrun_o
);
  localparam int DcW = $clog2(RdLatency + 1);
  state_t state, state_nx;
  logic [AddrW-1:0] addr;
  logic [DcW-1:0] drain_cnt;
  logic [15:0] frame_cnt;
  logic sub_bg, go, drain_done;
  tag_t pipe [RdLatency];
  tag_t tag_in, tag_out;
  logic [31:0] word;
  assign go = state == IDLE && start_i && !abort_i;
  assign drain_done = state == DRAIN && drain_cnt == DcW'(RdLatency);
  assign tag_out = pipe[RdLatency-1];
  assign busy_o = state != IDLE;
  assign port_sel_o = busy_o;
  assign rd_addr_o = addr;
  assign bg_addr_o = addr[9:0];
  assign y0_o = word[15:0];
  assign y0z_o = word[31:16];
  // next state; the header tag enters the pipe one cycle early so it lands right before word 0
  always_comb begin
    state_nx = abort_i ? IDLE
             : state == IDLE ? (go ? HDR : IDLE)
             : state == HDR ? READ
             : state == READ ? (addr == LastAddr ? DRAIN : READ)
             : (drain_done ? IDLE : DRAIN);
    tag_in = '{vld: go || state == HDR || state == READ, hdr: go, lst: state == READ && addr == LastAddr};
  end
  // state register
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) state <= IDLE;
    else state <= state_nx;
  // address, drain, frame counters plus latched mode and sticky overrun
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      addr <= '0;
      drain_cnt <= '0;
      frame_cnt <= '0;
      sub_bg <= 1'b0;
      overrun_o <= 1'b0;
    end else begin
      addr <= state_nx == READ ? addr + AddrW'(1) : state_nx == IDLE ? '0 : addr;
      drain_cnt <= state == DRAIN ? drain_cnt + DcW'(1) : '0;
      frame_cnt <= frame_cnt + 16'(drain_done && !abort_i);
      sub_bg <= go ? sub_bg_en_i : sub_bg;
      overrun_o <= overrun_o || (start_i && state != IDLE);
    end
  // valid/tag shift register matching the DPRAM read latency; abort flushes it
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      for (int i = 0; i < RdLatency; i++) pipe[i] <= '0;
    end else begin
      pipe[0] <= abort_i ? '0 : tag_in;
      for (int i = 1; i < RdLatency; i++) pipe[i] <= abort_i ? '0 : pipe[i-1];
    end
  // output flags registered alongside the compute stage
  always_ff @(posedge clk_i or negedge rst_n_i)
    if (!rst_n_i) begin
      data_valid_o <= 1'b0;
      frame_last_o <= 1'b0;
    end else begin
      data_valid_o <= !abort_i && tag_out.vld;
      frame_last_o <= !abort_i && tag_out.lst;
    end
  spec_readout_ctrl_bg_sub_sat u_sub (
    .clk_i   (clk_i),
    .rst_n_i (rst_n_i),
    .clr     (abort_i),
    .en      (tag_out.vld),
    .sub     (sub_bg && !tag_out.hdr),
    .a       (tag_out.hdr ? {HdrMagic, frame_cnt} : rd_data_i),
    .b       (bg_data_i),
    .q       (word)
  );
endmodule

// File: tb/tb_spec_readout_ctrl.sv
// tb_spec_readout_ctrl: random-stimulus stream checker against an arithmetic reference
module tb_spec_readout_ctrl;
  import spec_readout_ctrl_pkg::*;
  localparam int N = Words;
  localparam int RdLat = 2;
  logic clk = 0, rst_n = 0, start = 0, abort = 0, sub_en = 0;
  logic [AddrW-1:0] rd_addr;
  logic [31:0] rd_data, bg_data, d1, b1;
  logic [9:0] bg_addr;
  logic port_sel, busy, dv, last, ovr;
  logic [15:0] y0, y0z;
  bit bgff = 0;
  int errors = 0, checks = 0;
  always #5 clk = ~clk;
  spec_readout_ctrl #(.RdLatency(RdLat)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .start_i(start), .abort_i(abort), .sub_bg_en_i(sub_en),
    .rd_addr_o(rd_addr), .rd_data_i(rd_data), .bg_addr_o(bg_addr), .bg_data_i(bg_data),
    .port_sel_o(port_sel), .busy_o(busy), .y0_o(y0), .y0z_o(y0z),
    .data_valid_o(dv), .frame_last_o(last), .overrun_o(ovr)
  );
  // two-cycle DPRAM models: spec[a]=a, bg[a]=a[9:0]>>1, optionally all-ones for bin 0
  always @(posedge clk) begin
    d1 <= 32'(rd_addr);
    rd_data <= d1;
    b1 <= (bgff && rd_addr < AddrW'(NofPoints)) ? 32'hFFFF_FFFF : 32'(bg_addr >> 1);
    bg_data <= b1;
  end
  function automatic logic [31:0] ref_word(input int a, input bit sub, input bit ff);
    longint s = a;
    longint b = (ff && a < NofPoints) ? 64'hFFFF_FFFF : longint'((a % NofPoints) / 2);
    return sub ? 32'((s > b) ? s - b : 0) : 32'(s);
  endfunction
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic run_frame(input bit sub, input bit ff, input int hdr, input int abort_at, input int start_at);
    int idx = 0, cyc = 0;
    bit done = 0, aborted = 0, seen_last = 0;
    bgff = ff;
    sub_en = sub;
    start = 1;
    @(negedge clk);
    start = 0;
    chk("busy_start", 32'(busy), 1);
    chk("port_sel_start", 32'(port_sel), 1);
    chk("addr_start", 32'(rd_addr), 0);
    while (!done && cyc < N + 40) begin
      @(negedge clk);
      cyc++;
      sub_en = 1'($urandom);
      if (seen_last) begin
        chk("busy_drop", 32'(busy), 0);
        done = 1;
      end
      if (dv) begin
        chk("word", {y0z, y0}, idx == 0 ? {16'hA55A, 16'(hdr)} : ref_word(idx - 1, sub, ff));
        chk("last", 32'(last), 32'(idx == N));
        idx++;
      end else begin
        chk("zero", {y0z, y0}, 0);
        if (idx > 0 && idx <= N) chk("contig", 32'(dv), 1);
      end
      seen_last = dv && last;
      start = start_at >= 0 && dv && idx - 1 == start_at;
      if (!done && abort_at >= 0 && busy && int'(rd_addr) == abort_at) begin
        abort = 1;
        @(negedge clk);
        abort = 0;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_dv", 32'(dv), 0);
        chk("abort_addr", 32'(rd_addr), 0);
        repeat (RdLat + 4) begin
          @(negedge clk);
          chk("post_abort_dv", 32'(dv), 0);
          chk("post_abort_busy", 32'(busy), 0);
        end
        chk("abort_hdr_seen", 32'(idx > 0), 1);
        done = 1;
        aborted = 1;
      end
    end
    start = 0;
    sub_en = 0;
    chk("frame_done", 32'(done), 1);
    if (!aborted) chk("count", idx, N + 1);
  endtask
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    repeat (3) @(negedge clk);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_port_sel", 32'(port_sel), 0);
    chk("rst_dv", 32'(dv), 0);
    chk("rst_word", {y0z, y0}, 0);
    chk("rst_addr", 32'(rd_addr), 0);
    chk("rst_ovr", 32'(ovr), 0);
    rst_n = 1;
    @(negedge clk);
    run_frame(0, 0, 0, -1, -1);
    chk("ovr_clear", 32'(ovr), 0);
    run_frame(1, 1, 1, -1, -1);
    run_frame(1'($urandom), 1'($urandom), 2, -1, int'($urandom_range(400, 600)));
    chk("ovr_set", 32'(ovr), 1);
    run_frame(1'($urandom), 0, 3, 100, -1);
    run_frame(0, 0, 3, int'($urandom_range(3, 2000)), -1);
    chk("ovr_sticky", 32'(ovr), 1);
    start = 1;
    @(negedge clk);
    start = 0;
    repeat ($urandom_range(10, 200)) @(negedge clk);
    chk("mid_busy", 32'(busy), 1);
    #2 rst_n = 0;
    #1;
    chk("arst_busy", 32'(busy), 0);
    chk("arst_port_sel", 32'(port_sel), 0);
    chk("arst_dv", 32'(dv), 0);
    chk("arst_word", {y0z, y0}, 0);
    chk("arst_addr", 32'(rd_addr), 0);
    chk("arst_ovr", 32'(ovr), 0);
    @(negedge clk);
    rst_n = 1;
    @(negedge clk);
    run_frame(0, 0, 0, int'($urandom_range(3, 50)), -1);
    start = 1;
    abort = 1;
    @(negedge clk);
    start = 0;
    abort = 0;
    repeat (6) begin
      chk("sa_busy", 32'(busy), 0);
      chk("sa_dv", 32'(dv), 0);
      @(negedge clk);
    end
    chk("sa_ovr", 32'(ovr), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
